// File: rtl/led_seq_pkg.sv
// Shared encodings for the LED output sequencer: command modes, FSM states and
// the repeat-field decode.
package led_seq_pkg;

  localparam logic [1:0] MODE_STEADY = 2'b00;
  localparam logic [1:0] MODE_DIM    = 2'b01;
  localparam logic [1:0] MODE_BLINK  = 2'b10;
  localparam logic [1:0] MODE_SWEEP  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_HOLD  = 2'b01,
    ST_BLINK = 2'b10,
    ST_SWEEP = 2'b11
  } state_t;

  // A repeat field of zero stands for 16 periods/steps.
  function automatic logic [4:0] repeat_count(input logic [3:0] r);
    return (r == 4'd0) ? 5'd16 : {1'b0, r};
  endfunction

endpackage

// File: rtl/led_output_sequencer_if.sv
// LED command channel: valid/ready handshake carrying mode, pattern, dim level
// and repeat count.
interface led_output_sequencer_if #(
  parameter int N_LEDS   = 3,
  parameter int PWM_BITS = 4
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_mode;
  logic [N_LEDS-1:0]   cmd_pattern;
  logic [PWM_BITS-1:0] cmd_level;
  logic [3:0]          cmd_repeat;

  modport master (
    output cmd_valid, cmd_mode, cmd_pattern, cmd_level, cmd_repeat,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_mode, cmd_pattern, cmd_level, cmd_repeat,
    output cmd_ready
  );
endinterface

// File: rtl/led_tick_gen.sv
// Visible-rate prescaler: tick is high in the last cycle of every TICK_DIV-cycle
// phase. clr restarts the phase so a new command always gets a full first phase.
module led_tick_gen #(
  parameter int TICK_DIV = 4194304
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);
  localparam int W = $clog2(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST) && !clr;

endmodule

// File: rtl/led_output_sequencer.sv
// LED output sequencer: steady, PWM dim, timed blink and rotating sweep.
//  state | meaning
//  IDLE  | LEDs off, ready for a command
//  HOLD  | steady or dimmed pattern (or final sweep pattern) held, ready
//  BLINK | alternating pattern/off phases, busy
//  SWEEP | rotating pattern one step per tick, busy
module led_output_sequencer
  import led_seq_pkg::*;
#(
  parameter int N_LEDS   = 3,
  parameter int TICK_DIV = 4194304,
  parameter int PWM_BITS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  led_output_sequencer_if.slave  cmd,
  output logic [N_LEDS-1:0]      leds,
  output logic                   busy,
  output logic                   done
);
  state_t              state, state_d;
  logic [N_LEDS-1:0]   leds_d, pat_q, pat_d;
  logic [PWM_BITS-1:0] lvl_q, lvl_d, pwm_cnt;
  logic [4:0]          rep_q, rep_d;
  logic                dim_q, dim_d, phase_q, phase_d, done_d;
  logic                accept, tick;

  assign cmd.cmd_ready = (state == ST_IDLE) || (state == ST_HOLD);
  assign busy          = (state == ST_BLINK) || (state == ST_SWEEP);
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;

  led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      leds    <= '0;
      pat_q   <= '0;
      lvl_q   <= '0;
      rep_q   <= '0;
      dim_q   <= 1'b0;
      phase_q <= 1'b0;
      done    <= 1'b0;
      pwm_cnt <= '0;
    end else begin
      state   <= state_d;
      leds    <= leds_d;
      pat_q   <= pat_d;
      lvl_q   <= lvl_d;
      rep_q   <= rep_d;
      dim_q   <= dim_d;
      phase_q <= phase_d;
      done    <= done_d;
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  always_comb begin
    state_d = state;
    leds_d  = leds;
    pat_d   = pat_q;
    lvl_d   = lvl_q;
    rep_d   = rep_q;
    dim_d   = dim_q;
    phase_d = phase_q;
    done_d  = 1'b0;

    if (accept) begin
      // New command drives the LEDs directly so HOLD-to-HOLD never passes through 0.
      pat_d   = cmd.cmd_pattern;
      lvl_d   = cmd.cmd_level;
      rep_d   = repeat_count(cmd.cmd_repeat);
      phase_d = 1'b1;
      dim_d   = 1'b0;
      leds_d  = cmd.cmd_pattern;
      case (cmd.cmd_mode)
        MODE_STEADY: state_d = ST_HOLD;
        MODE_DIM: begin
          state_d = ST_HOLD;
          dim_d   = 1'b1;
          leds_d  = cmd.cmd_pattern & {N_LEDS{pwm_cnt < cmd.cmd_level}};
        end
        MODE_BLINK:  state_d = ST_BLINK;
        default:     state_d = ST_SWEEP;
      endcase
    end else begin
      case (state)
        ST_IDLE: leds_d = '0;
        ST_HOLD: begin
          if (dim_q) leds_d = pat_q & {N_LEDS{pwm_cnt < lvl_q}};
        end
        ST_BLINK: begin
          if (tick) begin
            if (phase_q) begin
              leds_d  = '0;
              phase_d = 1'b0;
            end else if (rep_q == 5'd1) begin
              leds_d  = '0;
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              leds_d  = pat_q;
              phase_d = 1'b1;
              rep_d   = rep_q - 5'd1;
            end
          end
        end
        default: begin
          if (tick) begin
            leds_d = {leds[N_LEDS-2:0], leds[N_LEDS-1]};
            if (rep_q == 5'd1) begin
              done_d  = 1'b1;
              state_d = ST_HOLD;
            end else begin
              rep_d = rep_q - 5'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_output_sequencer.sv
// Directed bench for led_output_sequencer with TICK_DIV=4: expected per-cycle
// LED/done/ready/busy values are queued with each command and popped at negedges.
module tb_led_output_sequencer;
  import led_seq_pkg::*;

  typedef struct packed {
    logic [2:0] leds;
    logic       done;
    logic       ready;
    logic       busy;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [2:0] leds;
  logic       busy;
  logic       done;
  int         errors;
  int         checks;
  exp_t       sb[$];

  led_output_sequencer_if #(.N_LEDS(3), .PWM_BITS(4)) bus ();

  led_output_sequencer #(.N_LEDS(3), .TICK_DIV(4), .PWM_BITS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cmd   (bus),
    .leds  (leds),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] l, input logic d, input logic r, input logic b, input int n);
    for (int i = 0; i < n; i++) sb.push_back('{leds: l, done: d, ready: r, busy: b});
  endtask

  task automatic run_cycles(input int n, input string tag);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL %s scoreboard empty at cycle %0d", tag, i);
      end else begin
        e = sb.pop_front();
        chk({tag, "_leds"},  8'(leds),          8'(e.leds));
        chk({tag, "_done"},  8'(done),          8'(e.done));
        chk({tag, "_ready"}, 8'(bus.cmd_ready), 8'(e.ready));
        chk({tag, "_busy"},  8'(busy),          8'(e.busy));
      end
    end
  endtask

  // Presents a command at a negedge; it is accepted on the following posedge.
  task automatic send(input logic [1:0] mode, input logic [2:0] pat, input logic [3:0] lvl,
                      input logic [3:0] rep);
    bus.cmd_mode    = mode;
    bus.cmd_pattern = pat;
    bus.cmd_level   = lvl;
    bus.cmd_repeat  = rep;
    bus.cmd_valid   = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  initial begin
    int on_cnt;
    int off_cnt;
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    bus.cmd_valid   = 1'b0;
    bus.cmd_mode    = MODE_STEADY;
    bus.cmd_pattern = 3'b000;
    bus.cmd_level   = 4'd0;
    bus.cmd_repeat  = 4'd0;

    repeat (2) @(negedge clk);
    chk("rst_leds",  8'(leds),          8'd0);
    chk("rst_ready", 8'(bus.cmd_ready), 8'd1);
    chk("rst_busy",  8'(busy),          8'd0);
    chk("rst_done",  8'(done),          8'd0);
    rst_n = 1'b1;

    // STEADY 101
    send(MODE_STEADY, 3'b101, 4'd0, 4'd0);
    push(3'b101, 1'b0, 1'b1, 1'b0, 5);
    run_cycles(5, "steady");

    // DIM 111 level 4: any 16 consecutive cycles hold exactly 4 on-cycles
    @(negedge clk);
    send(MODE_DIM, 3'b111, 4'd4, 4'd0);
    on_cnt = 0;
    off_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (leds == 3'b111) on_cnt++;
      if (leds == 3'b000) off_cnt++;
    end
    chk("dim4_on",  8'(on_cnt),  8'd4);
    chk("dim4_off", 8'(off_cnt), 8'd12);

    send(MODE_DIM, 3'b111, 4'd0, 4'd0);
    push(3'b000, 1'b0, 1'b1, 1'b0, 16);
    run_cycles(16, "dim0");

    // BLINK 011, repeat 2
    @(negedge clk);
    send(MODE_BLINK, 3'b011, 4'd0, 4'd2);
    push(3'b011, 1'b0, 1'b0, 1'b1, 4);
    push(3'b000, 1'b0, 1'b0, 1'b1, 4);
    push(3'b011, 1'b0, 1'b0, 1'b1, 4);
    push(3'b000, 1'b0, 1'b0, 1'b1, 4);
    push(3'b000, 1'b1, 1'b1, 1'b0, 1);
    push(3'b000, 1'b0, 1'b1, 1'b0, 1);
    run_cycles(18, "blink2");

    // SWEEP 001, repeat 4
    send(MODE_SWEEP, 3'b001, 4'd0, 4'd4);
    push(3'b001, 1'b0, 1'b0, 1'b1, 4);
    push(3'b010, 1'b0, 1'b0, 1'b1, 4);
    push(3'b100, 1'b0, 1'b0, 1'b1, 4);
    push(3'b001, 1'b0, 1'b0, 1'b1, 4);
    push(3'b010, 1'b1, 1'b1, 1'b0, 1);
    push(3'b010, 1'b0, 1'b1, 1'b0, 3);
    run_cycles(20, "sweep4");

    // STEADY 110 held valid during a 1-period BLINK
    send(MODE_BLINK, 3'b011, 4'd0, 4'd1);
    bus.cmd_mode    = MODE_STEADY;
    bus.cmd_pattern = 3'b110;
    bus.cmd_repeat  = 4'd0;
    bus.cmd_valid   = 1'b1;
    push(3'b011, 1'b0, 1'b0, 1'b1, 4);
    push(3'b000, 1'b0, 1'b0, 1'b1, 4);
    push(3'b000, 1'b1, 1'b1, 1'b0, 1);
    push(3'b110, 1'b0, 1'b1, 1'b0, 1);
    run_cycles(10, "stall");
    bus.cmd_valid = 1'b0;
    push(3'b110, 1'b0, 1'b1, 1'b0, 2);
    run_cycles(2, "stall_hold");

    // Asynchronous reset in the middle of a BLINK
    send(MODE_BLINK, 3'b011, 4'd0, 4'd2);
    push(3'b011, 1'b0, 1'b0, 1'b1, 3);
    run_cycles(3, "pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_leds",  8'(leds),          8'd0);
    chk("arst_busy",  8'(busy),          8'd0);
    chk("arst_ready", 8'(bus.cmd_ready), 8'd1);
    chk("arst_done",  8'(done),          8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // BLINK 001, repeat 0 -> 16 periods
    send(MODE_BLINK, 3'b001, 4'd0, 4'd0);
    for (int p = 0; p < 16; p++) begin
      push(3'b001, 1'b0, 1'b0, 1'b1, 4);
      push(3'b000, 1'b0, 1'b0, 1'b1, 4);
    end
    push(3'b000, 1'b1, 1'b1, 1'b0, 1);
    push(3'b000, 1'b0, 1'b1, 1'b0, 1);
    run_cycles(130, "blink16");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
